vend_dispense_ctrl: RTL and testbench

//  Downstream stage of the vending FSM. Consumes its per-cycle dispense pulse (out) and change code.

---
 rtl/vend_dispense_ctrl.sv | 146 ++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer behind the vending FSM: queues vend and change requests, times the
// bottle motor and the Rs5 hopper solenoid, and tracks bottle stock with refund on sell-out.
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES = 8,
  parameter int HOPPER_ON    = 4,
  parameter int HOPPER_GAP   = 4,
  parameter int STOCK_INIT   = 16,
  parameter int STOCK_W      = 5,
  parameter int PEND_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vend_in,
  input  logic [1:0]         change_in,
  input  logic               restock,
  output logic               motor_en,
  output logic               hopper_en,
  output logic [STOCK_W-1:0] stock,
  output logic               sold_out,
  output logic               busy,
  output logic               err_ovf
);

  // state   | meaning
  // IDLE    | waiting; dispatches a pending vend first, otherwise a pending coin
  // MOTOR   | motor_en held high for MOTOR_CYCLES
  // HOP_ON  | hopper_en held high for HOPPER_ON (exactly one Rs5 coin)
  // HOP_GAP | hopper settle time of HOPPER_GAP cycles before returning to IDLE
  typedef enum logic [1:0] {ST_IDLE, ST_MOTOR, ST_HOP_ON, ST_HOP_GAP} state_t;

  localparam int T_MAX = (MOTOR_CYCLES > HOPPER_ON)
                         ? ((MOTOR_CYCLES > HOPPER_GAP) ? MOTOR_CYCLES : HOPPER_GAP)
                         : ((HOPPER_ON > HOPPER_GAP) ? HOPPER_ON : HOPPER_GAP);
  localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int CMP_W = (STOCK_W > PEND_W) ? STOCK_W : PEND_W;
  localparam int SUM_W = PEND_W + 3;

  localparam logic [TMR_W-1:0]   T_MOTOR    = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0]   T_HOP_ON   = TMR_W'(HOPPER_ON - 1);
  localparam logic [TMR_W-1:0]   T_HOP_GAP  = TMR_W'(HOPPER_GAP - 1);
  localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_INIT);
  localparam logic [PEND_W-1:0]  PEND_FULL  = '1;
  localparam logic [SUM_W-1:0]   PEND_MAX   = SUM_W'(PEND_FULL);

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [PEND_W-1:0]  pend_vend;
  logic [PEND_W-1:0]  pend_coin;

  logic               vend_acc;
  logic               refund;
  logic [2:0]         coin_add;
  logic               start_vend;
  logic               start_coin;
  logic [SUM_W-1:0]   vend_sum;
  logic [SUM_W-1:0]   coin_sum;
  logic               vend_sat;
  logic               coin_sat;

  // A vend is only accepted if a bottle remains beyond those already queued,
  // so stock can never be driven below zero by the motor path.
  always_comb begin
    vend_acc   = vend_in && (CMP_W'(stock) > CMP_W'(pend_vend));
    refund     = vend_in && !vend_acc;
    coin_add   = refund ? 3'd3 : 3'd0;
    case (change_in)
      2'b01:   coin_add = coin_add + 3'd1;
      2'b10:   coin_add = coin_add + 3'd2;
      default: coin_add = coin_add;
    endcase
    start_vend = (state == ST_IDLE) && (pend_vend != '0);
    start_coin = (state == ST_IDLE) && (pend_vend == '0) && (pend_coin != '0);
    vend_sum   = SUM_W'(pend_vend) + SUM_W'(vend_acc) - SUM_W'(start_vend);
    coin_sum   = SUM_W'(pend_coin) + SUM_W'(coin_add) - SUM_W'(start_coin);
    vend_sat   = vend_sum > PEND_MAX;
    coin_sat   = coin_sum > PEND_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      pend_vend <= '0;
      pend_coin <= '0;
      stock     <= STOCK_LOAD;
      motor_en  <= 1'b0;
      hopper_en <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_ovf   <= err_ovf | vend_sat | coin_sat | (change_in == 2'b11);
      pend_vend <= vend_sat ? PEND_FULL : vend_sum[PEND_W-1:0];
      pend_coin <= coin_sat ? PEND_FULL : coin_sum[PEND_W-1:0];

      if (restock)
        stock <= STOCK_LOAD - STOCK_W'(start_vend);
      else if (start_vend)
        stock <= stock - STOCK_W'(1);

      case (state)
        ST_IDLE: begin
          if (start_vend) begin
            state    <= ST_MOTOR;
            motor_en <= 1'b1;
            timer    <= T_MOTOR;
          end else if (start_coin) begin
            state     <= ST_HOP_ON;
            hopper_en <= 1'b1;
            timer     <= T_HOP_ON;
          end
        end
        ST_MOTOR: begin
          if (timer == '0) begin
            state    <= ST_IDLE;
            motor_en <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_HOP_ON: begin
          if (timer == '0) begin
            state     <= ST_HOP_GAP;
            hopper_en <= 1'b0;
            timer     <= T_HOP_GAP;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_HOP_GAP: begin
          if (timer == '0)
            state <= ST_IDLE;
          else
            timer <= timer - TMR_W'(1);
        end
        default: begin
          state     <= ST_IDLE;
          motor_en  <= 1'b0;
          hopper_en <= 1'b0;
        end
      endcase
    end
  end

  assign sold_out = (stock == '0);
  assign busy     = (state != ST_IDLE) || (pend_vend != '0) || (pend_coin != '0);

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench for vend_dispense_ctrl: directed requests push expected drive pulses,
// a negedge monitor measures each motor/hopper pulse and compares it with the queue head.
module tb_vend_dispense_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       vend_in;
  logic [1:0] change_in;
  logic       restock;
  logic       motor_en;
  logic       hopper_en;
  logic [4:0] stock;
  logic       sold_out;
  logic       busy;
  logic       err_ovf;

  int checks = 0;
  int errors = 0;

  // kind: 0 = motor, 1 = hopper coin; gap = low cycles before this pulse, -1 = don't care
  typedef struct {int kind; int len; int gap;} exp_t;
  exp_t q[$];
  exp_t e;
  bit   in_pulse = 1'b0;
  int   cur_kind, cur_len, cur_gap;
  int   gap_cnt = 0;

  localparam int M = 0;
  localparam int C = 1;

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .clk(clk), .rst(rst), .vend_in(vend_in), .change_in(change_in), .restock(restock),
    .motor_en(motor_en), .hopper_en(hopper_en), .stock(stock), .sold_out(sold_out),
    .busy(busy), .err_ovf(err_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int len, input int gap);
    exp_t x;
    x.kind = kind; x.len = len; x.gap = gap;
    q.push_back(x);
  endtask

  // Monitor: one pulse = run of negedges with a drive high.
  always @(negedge clk) begin
    if (motor_en === 1'b1 || hopper_en === 1'b1) begin
      chk("no_overlap", int'(motor_en & hopper_en), 0);
      if (!in_pulse) begin
        in_pulse = 1'b1;
        cur_kind = (hopper_en === 1'b1) ? C : M;
        cur_len  = 0;
        cur_gap  = gap_cnt;
      end
      cur_len++;
    end else begin
      if (in_pulse) begin
        in_pulse = 1'b0;
        chk("pulse_expected", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("pulse_kind", cur_kind, e.kind);
          chk("pulse_len", cur_len, e.len);
          if (e.gap >= 0) chk("pulse_gap", cur_gap, e.gap);
        end
        gap_cnt = 0;
      end
      gap_cnt++;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(!busy && !in_pulse && q.size() == 0) && n < 3000);
    chk({name, "_queue_drained"}, q.size(), 0);
    chk({name, "_busy"}, int'(busy), 0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vend_in = 1'b0; change_in = 2'b00; restock = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_motor", int'(motor_en), 0);
    chk("rst_hopper", int'(hopper_en), 0);
    chk("rst_stock", int'(stock), 16);
    chk("rst_sold_out", int'(sold_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_ovf), 0);
    rst = 1'b0;

    // T1: single vend, 1-cycle latency, 8-cycle motor
    @(negedge clk); vend_in = 1'b1; push(M, 8, -1);
    @(negedge clk); vend_in = 1'b0;
    chk("t1_not_yet", int'(motor_en), 0);
    chk("t1_busy", int'(busy), 1);
    @(negedge clk);
    chk("t1_motor_on", int'(motor_en), 1);
    chk("t1_stock", int'(stock), 15);
    wait_idle("t1");

    // T2: Rs10 change = two coins; HOP_GAP holds 4 cycles then IDLE spends one dispatching
    @(negedge clk); change_in = 2'b10; push(C, 4, -1); push(C, 4, 5);
    @(negedge clk); change_in = 2'b00;
    wait_idle("t2");
    chk("t2_stock", int'(stock), 15);
    chk("t2_err", int'(err_ovf), 0);

    // T3: vend and Rs5 together: motor first, coin one IDLE cycle later
    @(negedge clk); vend_in = 1'b1; change_in = 2'b01; push(M, 8, -1); push(C, 4, 1);
    @(negedge clk); vend_in = 1'b0; change_in = 2'b00;
    wait_idle("t3");
    chk("t3_stock", int'(stock), 14);

    // T4: restock, drain 16 back-to-back vends, then a refund at stock 0
    @(negedge clk); restock = 1'b1;
    @(negedge clk); restock = 1'b0;
    chk("t4_restock", int'(stock), 16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); vend_in = 1'b1; push(M, 8, (i == 0) ? -1 : 1);
    end
    @(negedge clk); vend_in = 1'b0;
    wait_idle("t4_drain");
    chk("t4_stock0", int'(stock), 0);
    chk("t4_sold_out", int'(sold_out), 1);
    @(negedge clk); vend_in = 1'b1; push(C, 4, -1); push(C, 4, 5); push(C, 4, 5);
    @(negedge clk); vend_in = 1'b0;
    wait_idle("t4_refund");
    chk("t4_stock_after", int'(stock), 0);
    chk("t4_sold_out_after", int'(sold_out), 1);
    chk("t4_err", int'(err_ovf), 0);

    // T5: two vends keep the FSM on the motor while Rs10 arrives for 10 cycles
    @(negedge clk); restock = 1'b1;
    @(negedge clk); restock = 1'b0;
    chk("t5_restock", int'(stock), 16);
    vend_in = 1'b1; push(M, 8, -1); push(M, 8, 1);
    @(negedge clk);
    @(negedge clk); vend_in = 1'b0; change_in = 2'b10;
    repeat (7) @(negedge clk);
    chk("t5_err_before_sat", int'(err_ovf), 0);
    repeat (3) @(negedge clk); change_in = 2'b00;
    chk("t5_err_sat", int'(err_ovf), 1);
    push(C, 4, 1);
    for (int i = 1; i < 15; i++) push(C, 4, 5);
    wait_idle("t5");
    chk("t5_err_sticky", int'(err_ovf), 1);
    chk("t5_stock", int'(stock), 14);

    // T6: reset while MOTOR timer==3 with two coins pending
    @(negedge clk); vend_in = 1'b1; change_in = 2'b10; push(M, 5, -1);
    @(negedge clk); vend_in = 1'b0; change_in = 2'b00;
    repeat (5) @(negedge clk);
    chk("t6_motor_before", int'(motor_en), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_motor_off", int'(motor_en), 0);
    chk("t6_hopper_off", int'(hopper_en), 0);
    chk("t6_stock", int'(stock), 16);
    chk("t6_err", int'(err_ovf), 0);
    chk("t6_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    wait_idle("t6");

    // T7: illegal change code sets the error without queueing a coin
    @(negedge clk); change_in = 2'b11;
    @(negedge clk); change_in = 2'b00;
    chk("t7_err", int'(err_ovf), 1);
    chk("t7_busy", int'(busy), 0);

    // T8: restock on the same edge a dispense starts loads STOCK_INIT-1
    @(negedge clk); vend_in = 1'b1; push(M, 8, -1);
    @(negedge clk); vend_in = 1'b0;
    wait_idle("t8_first");
    chk("t8_stock15", int'(stock), 15);
    @(negedge clk); vend_in = 1'b1; push(M, 8, -1);
    @(negedge clk); vend_in = 1'b0; restock = 1'b1;
    @(negedge clk); restock = 1'b0;
    chk("t8_restock_start", int'(stock), 15);
    wait_idle("t8");
    chk("t8_stock_final", int'(stock), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
